// File: rtl/y_div_pkg.sv
// rtl/y_div_pkg.sv - shared types and constants for the y_divider slice
//
// Contents:
//   WIDTH_DEFAULT  default operand/quotient/remainder width
//   CNT_W_DEFAULT  default iteration counter width (2**CNT_W > WIDTH)
//   div_state_t    divider FSM states (IDLE, RUN, DONE)
//   DBZ_QUOTIENT   quotient reported for a divide-by-zero (all ones)

package y_div_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [WIDTH_DEFAULT-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/y_sub_stage.sv
// rtl/y_sub_stage.sv - combinational WIDTH+1-bit trial subtractor
//
// Computes a - b as a + ~b + 1 at WIDTH+1 bits.
// Ports:
//   a     in   WIDTH+1  minuend (shifted partial remainder)
//   b     in   WIDTH+1  subtrahend (zero-extended divisor)
//   diff  out  WIDTH    low WIDTH bits of the difference
//   neg   out  1        difference is negative (bit WIDTH of the result)

module y_sub_stage
  import y_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);

  localparam logic [WIDTH:0] CIN = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] full;

  // Two's-complement subtraction: the carry-in supplies the +1.
  assign full = a + ~b + CIN;
  assign diff = full[WIDTH-1:0];
  // The partial remainder is always below twice the divisor, so a
  // non-negative difference fits in WIDTH bits and bit WIDTH is a clean sign.
  assign neg  = full[WIDTH];

endmodule

// File: rtl/y_divider.sv
// rtl/y_divider.sv - iterative restoring divider for DIV/DIVU in the EX stage
//
// One quotient bit per clock; WIDTH cycles from accept to result.
// Optional feature macro: Y_DIVIDER_SIGNED_DIV_EN (adds is_signed input).
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset
//   in_valid     in   1      operands present
//   in_ready     out  1      divider can accept operands (IDLE)
//   dividend     in   WIDTH  numerator, sampled at accept
//   divisor      in   WIDTH  denominator, sampled at accept
//   is_signed    in   1      signed operation (only with Y_DIVIDER_SIGNED_DIV_EN)
//   out_valid    out  1      result present (DONE)
//   out_ready    in   1      consumer accepts result
//   quotient     out  WIDTH  result quotient
//   remainder    out  WIDTH  result remainder
//   div_by_zero  out  1      result was produced with divisor == 0

module y_divider
  import y_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef Y_DIVIDER_SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DBZ_Q      = {WIDTH{DBZ_QUOTIENT[0]}};

  div_state_t state, state_next;

  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] div_reg;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             divisor_zero;
  logic             last_iter;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  assign accept       = in_valid && in_ready;
  assign divisor_zero = (divisor == '0);
  assign last_iter    = (state == RUN) && (count == LAST_COUNT);

  // ------------------------------------------------------------------
  // Operand conditioning and sign fix-up
  // ------------------------------------------------------------------
`ifdef Y_DIVIDER_SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = is_signed && dividend[WIDTH-1];
  assign dvs_neg = is_signed && divisor[WIDTH-1];
  // The most negative value maps onto itself, which as an unsigned
  // magnitude is exactly right, so overflow needs no special case.
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;

  assign q_final = neg_q ? (~q_next + ONE) : q_next;
  assign r_final = neg_r ? (~rem_next + ONE) : rem_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && !divisor_zero) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_final = q_next;
  assign r_final = rem_next;
`endif

  // ------------------------------------------------------------------
  // One restoring iteration: shift {rem_acc, q_acc} left, trial subtract
  // ------------------------------------------------------------------
  assign rem_shift = {rem_acc, q_acc[WIDTH-1]};

  y_sub_stage #(
    .WIDTH(WIDTH)
  ) u_sub_stage (
    .a    (rem_shift),
    .b    ({1'b0, div_reg}),
    .diff (trial),
    .neg  (trial_neg)
  );

  // On a negative trial the shifted remainder is below the divisor, so its
  // top bit is zero and the low WIDTH bits hold the whole value.
  assign rem_next = trial_neg ? rem_shift[WIDTH-1:0] : trial;
  assign q_next   = {q_acc[WIDTH-2:0], ~trial_neg};

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == LAST_COUNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_acc     <= '0;
      q_acc       <= '0;
      div_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (divisor_zero) begin
              quotient    <= DBZ_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_acc <= '0;
              q_acc   <= dvd_mag;
              div_reg <= dvs_mag;
              count   <= '0;
            end
          end
        end
        RUN: begin
          rem_acc <= rem_next;
          q_acc   <= q_next;
          count   <= count + CNT_ONE;
          // Results are captured from the final iteration's accumulators
          // so DONE presents them with no extra cycle.
          if (last_iter) begin
            quotient  <= q_final;
            remainder <= r_final;
          end
        end
        DONE: begin
          if (out_ready) begin
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y_divider.sv
// tb/tb_y_divider.sv - directed self-checking bench for y_divider

module tb_y_divider;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef Y_DIVIDER_SIGNED_DIV_EN
  logic        is_signed;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks;
  int passed;

  y_divider dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef Y_DIVIDER_SIGNED_DIV_EN
    .is_signed   (is_signed),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one accept edge, then scramble the inputs.
  task automatic do_accept(input logic [31:0] a, input logic [31:0] b,
                           input logic s, output logic rdy);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
`ifdef Y_DIVIDER_SIGNED_DIV_EN
    is_signed = s;
`endif
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0;
  endtask

  // Count edges after the accept edge until out_valid; bounded at 100.
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (quotient !== 32'h0) $display("FAIL rst_quotient: got %h want 0", quotient); else passed++;
    checks++; if (remainder !== 32'h0) $display("FAIL rst_remainder: got %h want 0", remainder); else passed++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL rst_dbz: got %b want 0", div_by_zero); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_unsigned_exact();
    logic rdy;
    int lat;
    do_accept(32'd100, 32'd7, 1'b0, rdy);
    checks++; if (rdy !== 1'b1) $display("FAIL exact_accept: got in_ready %b want 1", rdy); else passed++;
    wait_valid(lat);
    checks++; if (lat != 32) $display("FAIL exact_latency: got %0d want 32", lat); else passed++;
    checks++; if (quotient !== 32'd14) $display("FAIL exact_q: got %0d want 14", quotient); else passed++;
    checks++; if (remainder !== 32'd2) $display("FAIL exact_r: got %0d want 2", remainder); else passed++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL exact_dbz: got %b want 0", div_by_zero); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL exact_busy: got in_ready %b want 0", in_ready); else passed++;
    pop();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL exact_drop: got out_valid %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL exact_idle: got in_ready %b want 1", in_ready); else passed++;
  endtask

  task automatic test_divisor_gt();
    logic rdy;
    int lat;
    do_accept(32'd5, 32'd9, 1'b0, rdy);
    wait_valid(lat);
    checks++; if (lat != 32) $display("FAIL small_latency: got %0d want 32", lat); else passed++;
    checks++; if (quotient !== 32'd0) $display("FAIL small_q: got %0d want 0", quotient); else passed++;
    checks++; if (remainder !== 32'd5) $display("FAIL small_r: got %0d want 5", remainder); else passed++;
    pop();
    do_accept(32'hFFFF_FFFF, 32'd1, 1'b0, rdy);
    wait_valid(lat);
    checks++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL max_q: got %h want ffffffff", quotient); else passed++;
    checks++; if (remainder !== 32'h0) $display("FAIL max_r: got %h want 0", remainder); else passed++;
    pop();
  endtask

  task automatic test_div_by_zero();
    logic rdy;
    int lat;
    do_accept(32'h1234, 32'h0, 1'b0, rdy);
    wait_valid(lat);
    // Result is registered on the accept edge itself.
    checks++; if (lat != 0) $display("FAIL dbz_latency: got %0d want 0", lat); else passed++;
    checks++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL dbz_q: got %h want ffffffff", quotient); else passed++;
    checks++; if (remainder !== 32'h1234) $display("FAIL dbz_r: got %h want 1234", remainder); else passed++;
    checks++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag: got %b want 1", div_by_zero); else passed++;
    pop();
    @(negedge clk);
    checks++; if (div_by_zero !== 1'b0) $display("FAIL dbz_clear: got %b want 0", div_by_zero); else passed++;
  endtask

  task automatic test_back_to_back();
    logic rdy;
    logic bad;
    int lat;
    do_accept(32'd50, 32'd5, 1'b0, rdy);
    wait_valid(lat);
    dividend = 32'd9;
    divisor  = 32'd3;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (quotient !== 32'd10 || remainder !== 32'd0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL bp_hold: got q %0d r %0d ov %b ir %b want 10 0 1 0", quotient, remainder, out_valid, in_ready); else passed++;
    in_valid = 1'b0;
    pop();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release: got out_valid %b want 0", out_valid); else passed++;
    do_accept(32'd9, 32'd3, 1'b0, rdy);
    checks++; if (rdy !== 1'b1) $display("FAIL b2b_accept: got in_ready %b want 1", rdy); else passed++;
    wait_valid(lat);
    checks++; if (lat != 32) $display("FAIL b2b_latency: got %0d want 32", lat); else passed++;
    checks++; if (quotient !== 32'd3) $display("FAIL b2b_q: got %0d want 3", quotient); else passed++;
    pop();
  endtask

  task automatic test_reset_mid_run();
    logic rdy;
    logic bad;
    int lat;
    do_accept(32'd1000, 32'd3, 1'b0, rdy);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_ov: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ir: got %b want 1", in_ready); else passed++;
    checks++; if (quotient !== 32'h0) $display("FAIL mid_rst_q: got %h want 0", quotient); else passed++;
    checks++; if (remainder !== 32'h0) $display("FAIL mid_rst_r: got %h want 0", remainder); else passed++;
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL mid_rst_no_result: got out_valid 1 want 0"); else passed++;
    do_accept(32'd81, 32'd9, 1'b0, rdy);
    wait_valid(lat);
    checks++; if (lat != 32) $display("FAIL post_rst_latency: got %0d want 32", lat); else passed++;
    checks++; if (quotient !== 32'd9) $display("FAIL post_rst_q: got %0d want 9", quotient); else passed++;
    checks++; if (remainder !== 32'd0) $display("FAIL post_rst_r: got %0d want 0", remainder); else passed++;
    pop();
  endtask

`ifdef Y_DIVIDER_SIGNED_DIV_EN
  task automatic test_signed();
    logic rdy;
    int lat;
    do_accept(32'hFFFF_FFF9, 32'd2, 1'b1, rdy);
    wait_valid(lat);
    checks++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL s_neg7_q: got %h want fffffffd", quotient); else passed++;
    checks++; if (remainder !== 32'hFFFF_FFFF) $display("FAIL s_neg7_r: got %h want ffffffff", remainder); else passed++;
    pop();
    do_accept(32'd7, 32'hFFFF_FFFE, 1'b1, rdy);
    wait_valid(lat);
    checks++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL s_7neg2_q: got %h want fffffffd", quotient); else passed++;
    checks++; if (remainder !== 32'd1) $display("FAIL s_7neg2_r: got %h want 1", remainder); else passed++;
    pop();
    do_accept(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rdy);
    wait_valid(lat);
    checks++; if (lat != 32) $display("FAIL s_ovf_latency: got %0d want 32", lat); else passed++;
    checks++; if (quotient !== 32'h8000_0000) $display("FAIL s_ovf_q: got %h want 80000000", quotient); else passed++;
    checks++; if (remainder !== 32'h0) $display("FAIL s_ovf_r: got %h want 0", remainder); else passed++;
    pop();
    do_accept(32'hFFFF_FFF9, 32'd2, 1'b0, rdy);
    wait_valid(lat);
    checks++; if (quotient !== 32'h7FFF_FFFC) $display("FAIL u_big_q: got %h want 7ffffffc", quotient); else passed++;
    checks++; if (remainder !== 32'd1) $display("FAIL u_big_r: got %h want 1", remainder); else passed++;
    pop();
  endtask
`endif

  initial begin
    checks    = 0;
    passed    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
`ifdef Y_DIVIDER_SIGNED_DIV_EN
    is_signed = 1'b0;
`endif
    test_reset();
    test_unsigned_exact();
    test_divisor_gt();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_run();
`ifdef Y_DIVIDER_SIGNED_DIV_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
